seg7_mux_ctrl: RTL and testbench

Parametrised, double-buffered 7-segment multiplex controller for the board display. Clients write per-digit content (hex nibble or raw segment pattern, DP, blink flag) into a shadow bank, then commit. The controller swaps the shadow bank into the active bank atomically at a frame boundary, then scans the digits. It adds PWM brightness, per-digit blink and inter-digit dead time for anti-ghosting. It replaces fixed-content key/score displays; game logic only writes digit records.

---
 rtl/seg7_mux_ctrl_if.sv | 48 ++++
 rtl/seg7_mux_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_seg7_mux_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_mux_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_mux_ctrl_if
//  Description : Client-side bus for the 7-segment multiplex controller.
//                It carries the digit-record write port, the commit handshake,
//                the brightness level and the display pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_mux_ctrl_if #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 4
);
    // Shadow-bank write port
    logic                   wr_en;
    logic [3:0]             wr_addr;
    logic                   wr_raw;
    logic [6:0]             wr_data;
    logic                   wr_dp;
    logic                   wr_blink;

    // Commit handshake and frame timing
    logic                   commit;
    logic                   commit_ack;
    logic                   frame_start;

    // Duty level, taken at frame boundaries only
    logic [BRIGHT_BITS-1:0] brightness;

    // Display pins, all active low
    logic [6:0]             SEG;
    logic [NUM_DIGITS-1:0]  AN;
    logic                   DP;

    // Client side: game logic or a test bench
    modport master (
        output wr_en, wr_addr, wr_raw, wr_data, wr_dp, wr_blink,
        output commit, brightness,
        input  commit_ack, frame_start, SEG, AN, DP
    );

    // Controller side
    modport slave (
        input  wr_en, wr_addr, wr_raw, wr_data, wr_dp, wr_blink,
        input  commit, brightness,
        output commit_ack, frame_start, SEG, AN, DP
    );
endinterface
`default_nettype wire

// File: rtl/seg7_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_mux_ctrl
//  Description : Double-buffered 7-segment multiplex controller. Clients write
//                digit records into a shadow bank and commit. The shadow bank
//                is copied into the active bank at a frame boundary. The
//                active bank is then scanned with PWM brightness, per-digit
//                blink and a one-cycle dead time at the start of every slot.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_mux_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 17,
    parameter int BRIGHT_BITS = 4,
    parameter int BLINK_DIV   = 26
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    seg7_mux_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DSEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DSEL_W-1:0]      c_last_digit  = DSEL_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_BITS-1:0] c_bright_full = '1;
    localparam logic [6:0]             c_seg_blank   = 7'h7F;

    // Commit tracking state machine
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [REFRESH_DIV-1:0] r_slot_cnt;
    logic [DSEL_W-1:0]      r_digit_sel;
    logic [BLINK_DIV:0]     r_blink_cnt;
    logic [BRIGHT_BITS-1:0] r_bright;
    logic [0:0]             r_state;

    // Shadow bank (written by the client)
    logic [NUM_DIGITS-1:0]  r_sh_raw;
    logic [NUM_DIGITS-1:0]  r_sh_dp;
    logic [NUM_DIGITS-1:0]  r_sh_blink;
    logic [6:0]             r_sh_data [NUM_DIGITS];

    // Active bank (scanned onto the pins)
    logic [NUM_DIGITS-1:0]  r_act_raw;
    logic [NUM_DIGITS-1:0]  r_act_dp;
    logic [NUM_DIGITS-1:0]  r_act_blink;
    logic [6:0]             r_act_data [NUM_DIGITS];

    // Registered pins and pulses
    logic [NUM_DIGITS-1:0]  r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_commit_ack;
    logic                   r_frame_start;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                   w_slot_last;
    logic                   w_boundary;
    logic [0:0]             w_state_next;
    logic                   w_copy;
    logic [NUM_DIGITS-1:0]  w_wr_hit;

    logic                   w_cur_raw;
    logic                   w_cur_dp;
    logic                   w_cur_blink;
    logic [6:0]             w_cur_data;
    logic [6:0]             w_hex_pat;
    logic [6:0]             w_pattern;

    logic [BRIGHT_BITS-1:0] w_pwm_level;
    logic                   w_pwm_on;
    logic                   w_dead;
    logic                   w_blink_off;
    logic                   w_enable;
    logic [NUM_DIGITS-1:0]  w_an_next;

    // A frame ends on the last cycle of the last digit's slot
    assign w_slot_last = &r_slot_cnt;
    assign w_boundary  = w_slot_last && (r_digit_sel == c_last_digit);

    // Per-digit write decode; out-of-range addresses match no digit
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_hit
            assign w_wr_hit[gi] = bus.wr_en && (bus.wr_addr == 4'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------------

    // Free-running slot counter, digit selector and blink counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_cnt  <= '0;
            r_digit_sel <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (w_slot_last) begin
                if (r_digit_sel == c_last_digit) begin
                    r_digit_sel <= '0;
                end else begin
                    r_digit_sel <= r_digit_sel + 1'b1;
                end
            end
        end
    end

    // Brightness is only taken at a frame boundary so a frame never mixes duty levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bright <= '1;
        end else if (w_boundary) begin
            r_bright <= bus.brightness;
        end
    end

    // ------------------------------------------------------------------------
    // Commit state machine: remembers a commit until the next boundary
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a commit on the boundary itself is served at once
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.commit && !w_boundary) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_boundary) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: copy the shadow bank when a boundary meets a commit request
    always_comb begin
        w_copy = 1'b0;
        if (w_boundary && ((r_state == ST_PENDING) || bus.commit)) begin
            w_copy = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Record banks
    // ------------------------------------------------------------------------

    // Shadow bank takes client writes; a write on the boundary lands after the copy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_sh_raw[i]   <= 1'b1;
                r_sh_data[i]  <= c_seg_blank;
                r_sh_dp[i]    <= 1'b0;
                r_sh_blink[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr_hit[i]) begin
                    r_sh_raw[i]   <= bus.wr_raw;
                    r_sh_data[i]  <= bus.wr_data;
                    r_sh_dp[i]    <= bus.wr_dp;
                    r_sh_blink[i] <= bus.wr_blink;
                end
            end
        end
    end

    // Active bank copies the pre-write shadow contents in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_act_raw[i]   <= 1'b1;
                r_act_data[i]  <= c_seg_blank;
                r_act_dp[i]    <= 1'b0;
                r_act_blink[i] <= 1'b0;
            end
        end else if (w_copy) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_act_raw[i]   <= r_sh_raw[i];
                r_act_data[i]  <= r_sh_data[i];
                r_act_dp[i]    <= r_sh_dp[i];
                r_act_blink[i] <= r_sh_blink[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------------

    // Select the active record of the digit currently being scanned
    always_comb begin
        w_cur_raw   = 1'b1;
        w_cur_data  = c_seg_blank;
        w_cur_dp    = 1'b0;
        w_cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_sel == DSEL_W'(i)) begin
                w_cur_raw   = r_act_raw[i];
                w_cur_data  = r_act_data[i];
                w_cur_dp    = r_act_dp[i];
                w_cur_blink = r_act_blink[i];
            end
        end
    end

    // Hex nibble to active-low gfedcba pattern
    always_comb begin
        w_hex_pat = c_seg_blank;
        case (w_cur_data[3:0])
            4'h0: w_hex_pat = 7'b1000000;
            4'h1: w_hex_pat = 7'b1111001;
            4'h2: w_hex_pat = 7'b0100100;
            4'h3: w_hex_pat = 7'b0110000;
            4'h4: w_hex_pat = 7'b0011001;
            4'h5: w_hex_pat = 7'b0010010;
            4'h6: w_hex_pat = 7'b0000010;
            4'h7: w_hex_pat = 7'b1111000;
            4'h8: w_hex_pat = 7'b0000000;
            4'h9: w_hex_pat = 7'b0010000;
            4'hA: w_hex_pat = 7'b0001000;
            4'hB: w_hex_pat = 7'b0000011;
            4'hC: w_hex_pat = 7'b1000110;
            4'hD: w_hex_pat = 7'b0100001;
            4'hE: w_hex_pat = 7'b0000110;
            4'hF: w_hex_pat = 7'b0001110;
            default: w_hex_pat = c_seg_blank;
        endcase
    end

    assign w_pattern = w_cur_raw ? w_cur_data : w_hex_pat;

    // ------------------------------------------------------------------------
    // Digit enable: dead time, PWM duty and blink blanking
    // ------------------------------------------------------------------------
    assign w_pwm_level = r_slot_cnt[REFRESH_DIV-1 -: BRIGHT_BITS];
    assign w_pwm_on    = (w_pwm_level < r_bright) || (r_bright == c_bright_full);
    assign w_dead      = (r_slot_cnt == '0);
    assign w_blink_off = w_cur_blink && !r_blink_cnt[BLINK_DIV];
    assign w_enable    = !w_dead && w_pwm_on && !w_blink_off;

    // One-cold anode vector; only a selected and enabled digit is driven low
    always_comb begin
        w_an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_enable && (r_digit_sel == DSEL_W'(i))) begin
                w_an_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------

    // Pins and pulses are registered one cycle behind the counter state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an          <= '1;
            r_seg         <= c_seg_blank;
            r_dp          <= 1'b1;
            r_commit_ack  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_next;
            r_seg         <= w_enable ? w_pattern : c_seg_blank;
            r_dp          <= w_enable ? ~w_cur_dp : 1'b1;
            r_commit_ack  <= w_copy;
            r_frame_start <= w_boundary;
        end
    end

    assign bus.AN          = r_an;
    assign bus.SEG         = r_seg;
    assign bus.DP          = r_dp;
    assign bus.commit_ack  = r_commit_ack;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_mux_ctrl
//  Description : Self-checking bench for seg7_mux_ctrl with a small digit
//                count. The reference model derives scan position, blink phase
//                and frame boundaries from a cycle count since reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_mux_ctrl;

    localparam int ND = 3;
    localparam int RD = 4;
    localparam int BB = 2;
    localparam int BD = 6;
    localparam int SLOT  = 1 << RD;    // 16 cycles per digit
    localparam int FRAME = ND * SLOT;  // 48 cycles per frame

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_mux_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

    seg7_mux_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BRIGHT_BITS(BB),
        .BLINK_DIV  (BD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int unsigned t;                 // cycles since reset release
    logic        s_raw [ND];
    logic [6:0]  s_data[ND];
    logic        s_dp  [ND];
    logic        s_blk [ND];
    logic        a_raw [ND];
    logic [6:0]  a_data[ND];
    logic        a_dp  [ND];
    logic        a_blk [ND];
    logic        m_pending;
    logic [1:0]  m_bright;

    logic [2:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ack;
    logic        e_fs;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40; 4'h1: p = 7'h79; 4'h2: p = 7'h24; 4'h3: p = 7'h30;
            4'h4: p = 7'h19; 4'h5: p = 7'h12; 4'h6: p = 7'h02; 4'h7: p = 7'h78;
            4'h8: p = 7'h00; 4'h9: p = 7'h10; 4'hA: p = 7'h08; 4'hB: p = 7'h03;
            4'hC: p = 7'h46; 4'hD: p = 7'h21; 4'hE: p = 7'h06; default: p = 7'h0E;
        endcase
        return p;
    endfunction

    // Predict the pins after the coming edge and advance the model by one cycle
    task automatic model_step();
        int  slot, dig;
        bit  phase, bound, en;
        logic [6:0] pat;
        if (!rst_n) begin
            for (int i = 0; i < ND; i++) begin
                s_raw[i] = 1'b1; s_data[i] = 7'h7F; s_dp[i] = 1'b0; s_blk[i] = 1'b0;
                a_raw[i] = 1'b1; a_data[i] = 7'h7F; a_dp[i] = 1'b0; a_blk[i] = 1'b0;
            end
            m_pending = 1'b0;
            m_bright  = 2'b11;
            e_an = 3'b111; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fs = 1'b0;
            t = 0;
        end else begin
            slot  = int'(t % SLOT);
            dig   = int'((t % FRAME) / SLOT);
            phase = ((t / 64) % 2) == 1;
            bound = (t % FRAME) == FRAME - 1;
            en    = (slot != 0) && ((m_bright == 2'b11) || ((slot / 4) < int'(m_bright)))
                    && !(a_blk[dig] && !phase);
            pat   = a_raw[dig] ? a_data[dig] : hex7(a_data[dig][3:0]);
            e_an  = 3'b111;
            if (en) e_an[dig] = 1'b0;
            e_seg = en ? pat : 7'h7F;
            e_dp  = en ? ~a_dp[dig] : 1'b1;
            e_fs  = bound;
            e_ack = bound && (m_pending || bus.commit);
            if (bound) m_bright = bus.brightness;
            if (e_ack) begin
                for (int i = 0; i < ND; i++) begin
                    a_raw[i] = s_raw[i]; a_data[i] = s_data[i];
                    a_dp[i]  = s_dp[i];  a_blk[i]  = s_blk[i];
                end
                m_pending = 1'b0;
            end else if (bus.commit) begin
                m_pending = 1'b1;
            end
            if (bus.wr_en && (bus.wr_addr < 4'(ND))) begin
                s_raw [bus.wr_addr[1:0]] = bus.wr_raw;
                s_data[bus.wr_addr[1:0]] = bus.wr_data;
                s_dp  [bus.wr_addr[1:0]] = bus.wr_dp;
                s_blk [bus.wr_addr[1:0]] = bus.wr_blink;
            end
            t++;
        end
    endtask

    // One clock cycle: predict, clock, then compare every pin after the edge
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        checks++;
        assert ({bus.AN, bus.SEG, bus.DP, bus.commit_ack, bus.frame_start}
                === {e_an, e_seg, e_dp, e_ack, e_fs})
        else begin
            errors++;
            $error("FAIL pins t=%0d got AN=%b SEG=%b DP=%b ack=%b fs=%b want AN=%b SEG=%b DP=%b ack=%b fs=%b",
                   t, bus.AN, bus.SEG, bus.DP, bus.commit_ack, bus.frame_start,
                   e_an, e_seg, e_dp, e_ack, e_fs);
        end
        checks++;
        assert ($countones(~bus.AN) <= 1)
        else begin
            errors++;
            $error("FAIL an_onecold got AN=%b want at most one low bit", bus.AN);
        end
    endtask

    task automatic write_rec(input logic [3:0] addr, input logic raw, input logic [6:0] data,
                             input logic dp, input logic blink);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_raw = raw;
        bus.wr_data = data; bus.wr_dp = dp; bus.wr_blink = blink;
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        cyc();
        bus.commit = 1'b0;
    endtask

    // Bounded wait for commit_ack
    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            cyc();
            seen = (bus.commit_ack === 1'b1);
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s got no commit_ack want commit_ack within %0d cycles", tag, 2 * FRAME);
        end
    endtask

    // Wait until the given anode is lit, then check the segment and DP pins
    task automatic expect_digit(input string tag, input logic [2:0] an,
                                input logic [6:0] seg, input logic dp);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            cyc();
            seen = (bus.AN === an);
        end
        checks++;
        assert (seen && bus.SEG === seg && bus.DP === dp) else begin
            errors++;
            $error("FAIL %s got AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
                   tag, bus.AN, bus.SEG, bus.DP, an, seg, dp);
        end
    endtask

    // Count lit-anode cycles over the first full frame after the next frame_start
    task automatic count_lit(input string tag, input int want);
        bit seen = 1'b0;
        int n = 0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            cyc();
            seen = (bus.frame_start === 1'b1);
        end
        for (int k = 0; k < FRAME; k++) begin
            cyc();
            if (bus.AN !== 3'b111) n++;
        end
        checks++;
        assert (seen && n == want) else begin
            errors++;
            $error("FAIL %s got lit=%0d fs_seen=%0d want lit=%0d", tag, n, seen, want);
        end
    endtask

    initial begin
        int fs_cnt, ack_cnt;
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_raw = 1'b0; bus.wr_data = '0;
        bus.wr_dp = 1'b0; bus.wr_blink = 1'b0; bus.commit = 1'b0; bus.brightness = 2'b11;

        // Reset state
        cyc();
        cyc();
        checks++;
        assert (bus.AN === 3'b111 && bus.SEG === 7'h7F && bus.DP === 1'b1
                && bus.commit_ack === 1'b0 && bus.frame_start === 1'b0) else begin
            errors++;
            $error("FAIL reset got AN=%b SEG=%b DP=%b want AN=111 SEG=1111111 DP=1",
                   bus.AN, bus.SEG, bus.DP);
        end

        // Idle scan: two frame_start pulses and no commit_ack in 100 cycles
        rst_n = 1'b1;
        fs_cnt = 0; ack_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (bus.frame_start === 1'b1) fs_cnt++;
            if (bus.commit_ack === 1'b1) ack_cnt++;
        end
        checks++;
        assert (fs_cnt == 2 && ack_cnt == 0) else begin
            errors++;
            $error("FAIL idle_pulses got fs=%0d ack=%0d want fs=2 ack=0", fs_cnt, ack_cnt);
        end

        // Three records, commit mid-frame
        write_rec(4'd0, 1'b0, 7'h0A, 1'b0, 1'b0);
        write_rec(4'd1, 1'b1, 7'b1000111, 1'b0, 1'b0);
        write_rec(4'd2, 1'b0, 7'h03, 1'b1, 1'b0);
        pulse_commit();
        wait_ack("commit1");
        expect_digit("dig0_hexA", 3'b110, 7'b0001000, 1'b1);
        expect_digit("dig1_raw",  3'b101, 7'b1000111, 1'b1);
        expect_digit("dig2_hex3", 3'b011, 7'b0110000, 1'b0);

        // Brightness levels
        bus.brightness = 2'd1;
        count_lit("bright1", 9);
        bus.brightness = 2'd0;
        count_lit("bright0", 0);
        bus.brightness = 2'd3;
        count_lit("bright3", 45);

        // Out-of-range address leaves the shadow bank alone
        write_rec(4'd5, 1'b1, 7'h00, 1'b1, 1'b1);
        pulse_commit();
        wait_ack("commit_addr5");
        expect_digit("addr5_ignored", 3'b110, 7'b0001000, 1'b1);

        // Commit and write on the boundary cycle itself
        while ((t % FRAME) != FRAME - 1) cyc();
        bus.commit = 1'b1;
        write_rec(4'd1, 1'b1, 7'h12, 1'b0, 1'b0);
        bus.commit = 1'b0;
        expect_digit("bound_old", 3'b101, 7'b1000111, 1'b1);
        pulse_commit();
        wait_ack("commit_bound");
        expect_digit("bound_new", 3'b101, 7'h12, 1'b1);

        // Blink on digit 0 over several blink periods
        write_rec(4'd0, 1'b0, 7'h0A, 1'b0, 1'b1);
        pulse_commit();
        for (int k = 0; k < 300; k++) cyc();

        // Reset mid-blink
        rst_n = 1'b0;
        cyc();
        checks++;
        assert (bus.AN === 3'b111 && bus.SEG === 7'h7F && bus.DP === 1'b1) else begin
            errors++;
            $error("FAIL midreset got AN=%b SEG=%b DP=%b want AN=111 SEG=1111111 DP=1",
                   bus.AN, bus.SEG, bus.DP);
        end
        rst_n = 1'b1;
        expect_digit("blank_after_reset", 3'b110, 7'h7F, 1'b1);

        // Randomized traffic with one reset in the middle
        for (int k = 0; k < 2000; k++) begin
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 4'($urandom_range(0, 5));
            bus.wr_raw   = 1'($urandom);
            bus.wr_data  = 7'($urandom);
            bus.wr_dp    = 1'($urandom);
            bus.wr_blink = ($urandom_range(0, 3) == 0);
            bus.commit   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 150) == 0) bus.brightness = 2'($urandom);
            rst_n = !(k == 1000);
            cyc();
        end
        bus.wr_en = 1'b0; bus.commit = 1'b0; rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
